led_seq_ctrl: RTL and testbench

LED_SEQ_CTRL -- requirements
Module: led_seq_ctrl

---
 rtl/led_seq_pkg.sv | 26 ++
 rtl/tick_gen.sv | 33 +++
 rtl/led_seq_ctrl.sv | 163 ++++++++++++++++
 tb/tb_led_seq_ctrl.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/led_seq_pkg.sv
// Shared encodings for the LED sequencer: pattern modes, FSM states and
// the width/wrap helper of the per-step base-tick counter.
package led_seq_pkg;

  typedef enum logic [1:0] {
    MODE_WALK_L = 2'b00,
    MODE_WALK_R = 2'b01,
    MODE_BLINK  = 2'b10,
    MODE_BOUNCE = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    HOLD = 2'b10
  } state_e;

  // speed is 2 bits, so one step spans at most 2^3 = 8 base ticks.
  localparam int STEP_CNT_W = 3;

  // Last value of the step counter before it wraps: 2^speed - 1.
  function automatic logic [STEP_CNT_W-1:0] step_wrap(input logic [1:0] spd);
    return (STEP_CNT_W'(1) << spd) - STEP_CNT_W'(1);
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Base tick generator: counts enabled cycles 0..TICK_DIV-1 and flags the
// cycle in which the count is about to wrap. clr has priority over en.
module tick_gen #(
  parameter int TICK_DIV = 250000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q;

  assign tick = en && (cnt_q == LAST);

  // Cycle counter: clear wins, otherwise advance and wrap while enabled.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state registers use non-blocking (<=) so every flop samples
    // pre-edge values regardless of the order blocks are evaluated in.
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/led_seq_ctrl.sv
// LED pattern sequencer. start latches mode/speed and loads the initial
// pattern; every TICK_DIV*2^speed counting cycles the pattern advances and
// step pulses. stop (highest priority) returns to IDLE with LEDs dark.
// Optional feature: define LED_SEQ_PAUSE_EN to build the pause input and
// the HOLD state; otherwise pause is ignored and HOLD is unreachable.
module led_seq_ctrl
  import led_seq_pkg::*;
#(
  parameter int TICK_DIV = 250000,
  parameter int LED_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  input  logic [1:0]       mode,
  input  logic [1:0]       speed,
  output logic [LED_W-1:0] led,
  output logic             busy,
  output logic             step
);

  state_e                state_q, state_d;
  mode_e                 mode_q, mode_d;
  logic [1:0]            speed_q, speed_d;
  logic                  dir_up_q, dir_up_d;
  logic [STEP_CNT_W-1:0] step_cnt_q, step_cnt_d;
  logic [LED_W-1:0]      led_q, led_d;
  logic                  step_q, step_d;
  logic                  pause_eff, tick_en, base_tick;

`ifdef LED_SEQ_PAUSE_EN
  assign pause_eff = pause;
  assign busy      = (state_q == RUN) || (state_q == HOLD);
`else
  logic unused_pause;
  assign unused_pause = pause;
  assign pause_eff    = 1'b0;
  assign busy         = (state_q == RUN);
`endif

  // Counting runs whenever a sequence is active and not held; the cycle
  // that leaves HOLD already counts, so the frozen span equals the pause.
  assign tick_en = busy && !pause_eff;

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (tick_en),
    .clr  (start || stop),
    .tick (base_tick)
  );

  function automatic logic [LED_W-1:0] init_pattern(input mode_e m);
    logic [LED_W-1:0] p;
    p = '0;
    case (m)
      MODE_WALK_R: p[LED_W-1] = 1'b1;
      MODE_BLINK:  p = '1;
      default:     p[0] = 1'b1;
    endcase
    return p;
  endfunction

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state: stop beats start, start beats pause.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    state_d = state_q;
    if (stop) begin
      state_d = IDLE;
    end else if (start) begin
      state_d = RUN;
`ifdef LED_SEQ_PAUSE_EN
    end else if (state_q == RUN && pause) begin
      state_d = HOLD;
    end else if (state_q == HOLD && !pause) begin
      state_d = RUN;
`endif
    end
  end

  // Datapath next values: reload on start, advance pattern on step wrap.
  always_comb begin
    mode_d     = mode_q;
    speed_d    = speed_q;
    dir_up_d   = dir_up_q;
    step_cnt_d = step_cnt_q;
    led_d      = led_q;
    step_d     = 1'b0;
    if (stop) begin
      dir_up_d   = 1'b1;
      step_cnt_d = '0;
      led_d      = '0;
    end else if (start) begin
      mode_d     = mode_e'(mode);
      speed_d    = speed;
      dir_up_d   = 1'b1;
      step_cnt_d = '0;
      led_d      = init_pattern(mode_e'(mode));
    end else if (base_tick) begin
      if (step_cnt_q == step_wrap(speed_q)) begin
        step_cnt_d = '0;
        step_d     = 1'b1;
        case (mode_q)
          MODE_WALK_L: led_d = {led_q[LED_W-2:0], led_q[LED_W-1]};
          MODE_WALK_R: led_d = {led_q[0], led_q[LED_W-1:1]};
          MODE_BLINK:  led_d = ~led_q;
          MODE_BOUNCE: begin
            if (dir_up_q) begin
              if (led_q[LED_W-1]) begin
                led_d    = led_q >> 1;
                dir_up_d = 1'b0;
              end else begin
                led_d = led_q << 1;
              end
            end else begin
              if (led_q[0]) begin
                led_d    = led_q << 1;
                dir_up_d = 1'b1;
              end else begin
                led_d = led_q >> 1;
              end
            end
          end
          default: led_d = led_q;
        endcase
      end else begin
        step_cnt_d = step_cnt_q + STEP_CNT_W'(1);
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q     <= MODE_WALK_L;
      speed_q    <= '0;
      dir_up_q   <= 1'b1;
      step_cnt_q <= '0;
      led_q      <= '0;
      step_q     <= 1'b0;
    end else begin
      mode_q     <= mode_d;
      speed_q    <= speed_d;
      dir_up_q   <= dir_up_d;
      step_cnt_q <= step_cnt_d;
      led_q      <= led_d;
      step_q     <= step_d;
    end
  end

  assign led  = led_q;
  assign step = step_q;

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Self-checking bench for led_seq_ctrl (TICK_DIV=4, LED_W=8). A position /
// cycle-count model predicts led, busy and step every cycle; directed
// scenarios add literal expectations, then a randomized phase follows.
module tb_led_seq_ctrl;

  localparam int TICK_DIV = 4;
  localparam int LED_W    = 8;
`ifdef LED_SEQ_PAUSE_EN
  localparam bit PAUSE_EN = 1'b1;
`else
  localparam bit PAUSE_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start, stop, pause;
  logic [1:0]       mode, speed;
  logic [LED_W-1:0] led;
  logic             busy, step;

  int n_checks = 0;
  int n_pass   = 0;
  bit cmp_en   = 1'b0;

  led_seq_ctrl #(.TICK_DIV(TICK_DIV), .LED_W(LED_W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .stop (stop),
    .pause(pause),
    .mode (mode),
    .speed(speed),
    .led  (led),
    .busy (busy),
    .step (step)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  // Behavioural model: the lit LED is tracked as a bit index (or a blink
  // level); a step happens every period-th counting cycle since start.
  logic [7:0] m_led  = 8'h00;
  logic       m_busy = 1'b0;
  logic       m_step = 1'b0;
  logic [1:0] m_mode = 2'b00;
  int         m_cyc = 0, m_period = TICK_DIV, m_pos = 0;
  bit         m_up = 1'b1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_led = 8'h00; m_busy = 1'b0; m_step = 1'b0; m_cyc = 0; m_up = 1'b1;
    end else begin
      m_step = 1'b0;
      if (stop) begin
        m_busy = 1'b0; m_led = 8'h00; m_cyc = 0;
      end else if (start) begin
        m_busy   = 1'b1;
        m_mode   = mode;
        m_period = TICK_DIV * (1 << speed);
        m_cyc    = 0;
        m_up     = 1'b1;
        m_pos    = (mode == 2'b01) ? 7 : 0;
        m_led    = (mode == 2'b10) ? 8'hFF : (8'h01 << m_pos);
      end else if (m_busy && !(PAUSE_EN && pause)) begin
        m_cyc++;
        if (m_cyc % m_period == 0) begin
          m_step = 1'b1;
          case (m_mode)
            2'b00: m_pos = (m_pos + 1) % 8;
            2'b01: m_pos = (m_pos + 7) % 8;
            2'b11: begin
              if (m_up && m_pos == 7)       begin m_up = 1'b0; m_pos = 6; end
              else if (!m_up && m_pos == 0) begin m_up = 1'b1; m_pos = 1; end
              else m_pos = m_up ? m_pos + 1 : m_pos - 1;
            end
            default: ;
          endcase
          m_led = (m_mode == 2'b10) ? ~m_led : (8'h01 << m_pos);
        end
      end
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("model_led", led, m_led);
      check("model_busy", busy, m_busy);
      check("model_step", step, m_step);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start(input logic [1:0] m, input logic [1:0] s);
    mode = m; speed = s; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; pause = 1'b0; mode = 2'b00; speed = 2'b00;
    cyc(3);
    check("reset_led", led, 8'h00);
    check("reset_busy", busy, 1'b0);
    check("reset_step", step, 1'b0);
    rst_n  = 1'b1;
    cmp_en = 1'b1;
    cyc(2);

    // Walk left, speed 0: step every 4 cycles, 0x80 wraps to 0x01.
    pulse_start(2'b00, 2'b00);
    check("wl_init", led, 8'h01);
    check("wl_busy", busy, 1'b1);
    cyc(3);
    check("wl_pre_step", step, 1'b0);
    cyc(1);
    check("wl_first", led, 8'h02);
    check("wl_first_step", step, 1'b1);
    cyc(4);  check("wl_second", led, 8'h04);
    cyc(20); check("wl_msb", led, 8'h80);
    cyc(4);  check("wl_wrap", led, 8'h01);
    pulse_stop();
    check("wl_stop_led", led, 8'h00);
    check("wl_stop_busy", busy, 1'b0);

    // Bounce, speed 1: step every 8 cycles, reverses at both ends.
    pulse_start(2'b11, 2'b01);
    check("bn_init", led, 8'h01);
    cyc(56); check("bn_top", led, 8'h80);
    cyc(8);  check("bn_back", led, 8'h40);
    cyc(48); check("bn_bottom", led, 8'h01);
    cyc(8);  check("bn_up_again", led, 8'h02);
    pulse_stop();

    // Blink for 3 steps, then start and stop together: stop wins.
    pulse_start(2'b10, 2'b00);
    check("bl_init", led, 8'hFF);
    cyc(12); check("bl_three", led, 8'h00);
    start = 1'b1; stop = 1'b1; mode = 2'b00;
    cyc(1);
    start = 1'b0; stop = 1'b0;
    check("bl_ss_led", led, 8'h00);
    check("bl_ss_busy", busy, 1'b0);
    cyc(12);
    check("bl_idle_led", led, 8'h00);

    // Walk right, async reset between edges mid-count.
    pulse_start(2'b01, 2'b00);
    check("wr_init", led, 8'h80);
    cyc(6);  check("wr_first", led, 8'h40);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_led_now", led, 8'h00);
    check("rst_busy_now", busy, 1'b0);
    check("rst_step_now", step, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(20);
    check("rst_stays_idle", busy, 1'b0);

    // Pause 10 cycles once led=0x04 (one cycle into that step).
    pulse_start(2'b00, 2'b00);
    cyc(9);  check("ps_at4", led, 8'h04);
    pause = 1'b1;
    cyc(10);
    check("ps_busy", busy, 1'b1);
`ifdef LED_SEQ_PAUSE_EN
    check("ps_frozen", led, 8'h04);
`else
    check("ps_running", led, 8'h10);
`endif
    pause = 1'b0;
    cyc(2);
`ifdef LED_SEQ_PAUSE_EN
    check("ps_remaining", led, 8'h04);
    check("ps_remaining_step", step, 1'b0);
    cyc(1);
    check("ps_resumed", led, 8'h08);
    check("ps_resumed_step", step, 1'b1);
`else
    check("ps_running2", led, 8'h20);
    cyc(1);
    check("ps_running3", led, 8'h20);
    check("ps_running3_step", step, 1'b0);
`endif
    pulse_stop();

    // Restart in RUN with a new mode; mode/speed changes in RUN ignored.
    pulse_start(2'b00, 2'b00);
    cyc(6);  check("rs_before", led, 8'h02);
    pulse_start(2'b01, 2'b00);
    check("rs_reload", led, 8'h80);
    mode = 2'b10; speed = 2'b11;
    cyc(3);
    check("rs_hold_led", led, 8'h80);
    check("rs_no_step", step, 1'b0);
    cyc(1);
    check("rs_first", led, 8'h40);
    check("rs_first_step", step, 1'b1);
    pulse_stop();

    // Randomized control traffic, checked every cycle against the model.
    for (int i = 0; i < 4000; i++) begin
      start = ($urandom_range(0, 39) == 0);
      stop  = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 29) == 0) pause = ~pause;
      mode  = 2'($urandom);
      speed = 2'($urandom);
      if ($urandom_range(0, 799) == 0) begin
        #2 rst_n = 1'b0;
        #1 rst_n = 1'b1;
      end
      @(negedge clk);
    end

    start = 1'b0; stop = 1'b0; pause = 1'b0;
    cyc(2);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
